// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16 -- 16-way round-robin arbiter with registered one-hot grant
// and encoded winner index.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   : an 8-bit hold counter forces a release after MAX_HOLD
//               cycles in GRANT and pulses `timeout` for one cycle.
//   undefined : no counter; a grant is held until `done` or the owner
//               drops its request; `timeout` is constant 0.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   req        in  16   level-sensitive request vector
//   done       in   1   owner releases the grant (sampled in GRANT only)
//   gnt        out 16   registered one-hot grant
//   gnt_idx    out  4   registered binary index of the set gnt bit
//   gnt_valid  out  1   registered OR of gnt
//   timeout    out  1   one-cycle pulse on a hold-limit release
//
// state   | meaning
// S_IDLE  | no owner, searching req from r_ptr upward
// S_GRANT | gnt driven for the owner until a release condition

module rr_arbiter_16 #(
    parameter int MAX_HOLD = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_idx,
    output logic        gnt_valid,
    output logic        timeout
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_ptr, w_ptr_nxt;
    logic [15:0] r_gnt, w_gnt_nxt;
    logic [3:0]  r_gnt_idx, w_gnt_idx_nxt;
    logic        r_gnt_valid, w_gnt_valid_nxt;

    logic        w_found;
    logic [3:0]  w_sel_idx;
    logic        w_expire;
    logic        w_release;

    // First set request in rotated order r_ptr, r_ptr+1, ... (4-bit wrap).
    always_comb begin
        logic [3:0] v_cand;
        w_found   = 1'b0;
        w_sel_idx = 4'd0;
        v_cand    = 4'd0;
        for (int i = 0; i < 16; i++) begin
            v_cand = r_ptr + 4'(i);
            if (!w_found && req[v_cand]) begin
                w_found   = 1'b1;
                w_sel_idx = v_cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [8:0] LP_LIMIT = 9'(MAX_HOLD);

    logic [7:0] r_hold_cnt;
    logic       r_timeout;

    // Release on the edge where the counter would reach MAX_HOLD, so the
    // owner sees exactly MAX_HOLD cycles of grant.
    assign w_expire = (({1'b0, r_hold_cnt} + 9'd1) == LP_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= (r_state == S_GRANT) && w_expire;
            if ((r_state == S_GRANT) && !w_release)
                r_hold_cnt <= r_hold_cnt + 8'd1;
            else
                r_hold_cnt <= 8'd0;
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_max_hold;

    assign w_expire          = 1'b0;
    assign w_unused_max_hold = (MAX_HOLD == 0);
    assign timeout           = 1'b0;
`endif

    assign w_release = done | ~req[r_gnt_idx] | w_expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= 4'd0;
            r_gnt       <= 16'd0;
            r_gnt_idx   <= 4'd0;
            r_gnt_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_gnt_nxt       = r_gnt;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_gnt_valid_nxt = r_gnt_valid;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt     = S_GRANT;
                    w_gnt_nxt       = 16'd1 << w_sel_idx;
                    w_gnt_idx_nxt   = w_sel_idx;
                    w_gnt_valid_nxt = 1'b1;
                end
            end
            S_GRANT: begin
                // Other requests are ignored; only the owner's events matter.
                if (w_release) begin
                    w_state_nxt     = S_IDLE;
                    w_ptr_nxt       = r_gnt_idx + 4'd1;
                    w_gnt_nxt       = 16'd0;
                    w_gnt_idx_nxt   = 4'd0;
                    w_gnt_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_rr_arbiter_16.sv
module tb_rr_arbiter_16;

    localparam int TB_MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN  = 1'b1;
    localparam int NP_CYC = 2;
`else
    localparam bit TO_EN  = 1'b0;
    localparam int NP_CYC = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;

    rr_arbiter_16 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Behavioural model: owner number (-1 = none), rotating start point,
    // cycles held so far.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < 16; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % 16]) m_owner = (m_ptr + k) % 16;
                end
                m_hold = 0;
            end else begin
                bit expire;
                expire = TO_EN && (m_hold + 1 == TB_MAX_HOLD);
                if (done || !req[m_owner] || expire) begin
                    m_ptr   = (m_owner + 1) % 16;
                    m_owner = -1;
                    m_to    = expire;
                    m_hold  = 0;
                end else begin
                    m_hold = m_hold + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        logic [15:0] e_gnt;
        logic [3:0]  e_idx;
        e_gnt = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
        e_idx = (m_owner >= 0) ? 4'(m_owner) : 4'd0;
        chk("model_cycle", {10'd0, gnt, gnt_idx, gnt_valid, timeout},
            {10'd0, e_gnt, e_idx, (m_owner >= 0), m_to});
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk_out(input string name, input logic [15:0] e_gnt, input logic [3:0] e_idx,
                           input logic e_val, input logic e_to);
        chk(name, {10'd0, gnt, gnt_idx, gnt_valid, timeout}, {10'd0, e_gnt, e_idx, e_val, e_to});
    endtask

    initial begin
        int exp_seq[3];
        rst_n = 1'b0;
        req   = 16'h0000;
        done  = 1'b0;
        step(2);
        chk_out("reset_zero", 16'h0000, 4'd0, 1'b0, 1'b0);

        // Reset mid-grant
        rst_n = 1'b1;
        req   = 16'h0001;
        step(1);
        chk_out("first_grant", 16'h0001, 4'd0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_out("async_reset", 16'h0000, 4'd0, 1'b0, 1'b0);
        req = 16'h0000;
        step(1);
        rst_n = 1'b1;
        step(1);

        // Rotation with wrap: 0, 15, 0, 15
        req = 16'h8001;
        step(1);
        chk_out("rot_g0", 16'h0001, 4'd0, 1'b1, 1'b0);
        exp_seq = '{15, 0, 15};
        for (int i = 0; i < 3; i++) begin
            done = 1'b1;
            step(1);
            chk_out("rot_release", 16'h0000, 4'd0, 1'b0, 1'b0);
            done = 1'b0;
            step(1);
            chk_out("rot_grant", 16'd1 << exp_seq[i], 4'(exp_seq[i]), 1'b1, 1'b0);
        end
        done = 1'b1;
        step(1);
        done = 1'b0;

        // Full contention: 0..15 then 0, one idle cycle between grants
        req = 16'hFFFF;
        for (int k = 0; k <= 16; k++) begin
            step(1);
            chk_out("full_grant", 16'd1 << (k % 16), 4'(k % 16), 1'b1, 1'b0);
            done = 1'b1;
            step(1);
            chk_out("full_idle", 16'h0000, 4'd0, 1'b0, 1'b0);
            done = 1'b0;
        end

        // Owner drop (pointer now 1)
        req = 16'h0220;
        step(1);
        chk_out("drop_g5", 16'h0020, 4'd5, 1'b1, 1'b0);
        req = 16'h0200;
        step(1);
        chk_out("drop_release", 16'h0000, 4'd0, 1'b0, 1'b0);
        step(1);
        chk_out("drop_g9", 16'h0200, 4'd9, 1'b1, 1'b0);
        done = 1'b1;
        step(1);
        done = 1'b0;

        // Non-preemption on idx 3
        req = 16'h0008;
        step(1);
        chk_out("np_g3", 16'h0008, 4'd3, 1'b1, 1'b0);
        req = 16'h001C;
        for (int c = 0; c < NP_CYC; c++) begin
            step(1);
            chk_out("np_hold", 16'h0008, 4'd3, 1'b1, 1'b0);
        end
        req = 16'h0000;
        step(2);

`ifdef ARB_TIMEOUT_EN
        // Pointer is 4: req 7 wins; after the timeout the pointer is 8,
        // so requester 0 must win next.
        req = 16'h0081;
        step(1);
        chk_out("to_g7", 16'h0080, 4'd7, 1'b1, 1'b0);
        for (int c = 0; c < TB_MAX_HOLD - 1; c++) begin
            step(1);
            chk_out("to_hold", 16'h0080, 4'd7, 1'b1, 1'b0);
        end
        step(1);
        chk_out("to_pulse", 16'h0000, 4'd0, 1'b0, 1'b1);
        step(1);
        chk_out("to_next_g0", 16'h0001, 4'd0, 1'b1, 1'b0);
        req = 16'h0000;
        step(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
